// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC selection and fixed-length I-cache line-refill sequencer
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   pc,
    input  logic                          icache_hit,
    input  logic                          id_stall,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          exc_valid,
    output logic [31:0]                   nextpc,
    output logic                          pc_we,
    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    input  logic                          mem_ack,
    output logic                          refill_we,
    output logic [$clog2(LINE_WORDS)-1:0] refill_idx,
    output logic                          tag_we,
    output logic                          busy
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << (IW + 2)) - 32'd1);

    typedef enum logic [1:0] {RUN, REQ, BEAT, FILL} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   cnt;
    logic [31:0]     miss_addr;
    logic            pend;
    logic            pend_exc;
    logic [31:0]     pend_pc;
    logic            last;

    assign last       = cnt == IW'(LINE_WORDS - 1);
    assign busy       = state != RUN;
    assign mem_req    = state == REQ;
    assign mem_addr   = miss_addr;
    assign tag_we     = state == FILL;
    assign refill_idx = state == BEAT ? cnt : '0;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_n;
    end

    // next-state, PC source selection and refill write strobe
    always_comb begin
        state_n   = state;
        nextpc    = pc;
        pc_we     = 1'b0;
        refill_we = 1'b0;
        case (state)
            RUN: begin
                if (exc_valid) begin
                    nextpc = EXC_VECTOR;
                    pc_we  = 1'b1;
                end else if (redirect_valid) begin
                    nextpc = redirect_pc;
                    pc_we  = 1'b1;
                end else if (!icache_hit) begin
                    state_n = REQ;
                end else if (!id_stall) begin
                    nextpc = pc + 32'd4;
                    pc_we  = 1'b1;
                end
            end
            REQ: begin
                refill_we = mem_ack;
                state_n   = mem_ack ? BEAT : REQ;
            end
            BEAT: begin
                refill_we = mem_ack;
                state_n   = mem_ack && last ? FILL : BEAT;
            end
            default: begin
                state_n = RUN;
                nextpc  = pend ? pend_pc : pc;
                pc_we   = pend;
            end
        endcase
        if (rst) begin
            nextpc = RESET_PC;
            pc_we  = 1'b0;
        end
    end

    // miss address, beat counter and redirects deferred until the line is filled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            miss_addr <= '0;
            pend      <= 1'b0;
            pend_exc  <= 1'b0;
            pend_pc   <= '0;
        end else begin
            if (state == RUN && !exc_valid && !redirect_valid && !icache_hit)
                miss_addr <= pc & LINE_MASK;
            if (refill_we)
                cnt <= cnt + 1'b1;
            if (state == REQ || state == BEAT) begin
                if (exc_valid) begin
                    pend     <= 1'b1;
                    pend_exc <= 1'b1;
                    pend_pc  <= EXC_VECTOR;
                end else if (redirect_valid && !pend_exc) begin
                    pend    <= 1'b1;
                    pend_pc <= redirect_pc;
                end
            end else if (state == FILL) begin
                pend     <= 1'b0;
                pend_exc <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the MIPS core. It drives the PC register's next-PC value and write enable (`hit`) and selects the next PC from four sources: sequential, branch/jump redirect, exception vector, or hold. On an I-cache miss it freezes the PC and runs a fixed-length line-refill burst to memory, then resumes fetch. It sits between the PC register, the I-cache tag/data arrays, the decode stage and the memory bus.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value presented on `nextpc` during reset.
- `EXC_VECTOR`, 32'h8000_0180, exception entry address.
- `LINE_WORDS`, 4, words per cache line; power of two, 2..16.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc` in 32: current PC from the PC register.
- `icache_hit` in 1: tag match for `pc` this cycle.
- `id_stall` in 1: decode cannot accept an instruction; hold PC.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: branch/jump target.
- `exc_valid` in 1: exception raised this cycle.
- `nextpc` out 32: value the PC register loads.
- `pc_we` out 1: PC register write enable (drives its `hit` input).
- `mem_req` out 1: burst read request, held until first `mem_ack`.
- `mem_addr` out 32: line-aligned burst base address.
- `mem_ack` in 1: one data word valid this cycle.
- `refill_we` out 1: write `mem_rdata` into the I-cache line.
- `refill_idx` out log2(LINE_WORDS): word index within the line.
- `tag_we` out 1: write tag/valid for the refilled line.
- `busy` out 1: high whenever state is not RUN.

## Operation
- States: RUN, REQ, BEAT, FILL. Reset state RUN.
- RUN, source priority: `exc_valid` → `nextpc`=EXC_VECTOR, `pc_we`=1; else `redirect_valid` → `redirect_pc`, `pc_we`=1; else `!icache_hit` → `pc_we`=0, latch `miss_addr`=`pc` with low log2(LINE_WORDS)+2 bits cleared, go REQ; else `id_stall` → `pc_we`=0; else `pc`+4, `pc_we`=1.
- Exception or redirect in the same cycle as a miss: the redirect wins, no refill starts.
- REQ: `mem_req`=1, `mem_addr`=`miss_addr`. First `mem_ack` → `refill_we`=1, `refill_idx`=0, counter=1, go BEAT.
- BEAT: each `mem_ack` → `refill_we`=1, `refill_idx`=counter, counter+1. Ack with counter=LINE_WORDS-1 → go FILL. No ack → wait, no writes.
- FILL: `tag_we`=1 for one cycle, go RUN. If a pending redirect exists, `pc_we`=1 with the pending target and the pending flag clears; otherwise `pc_we`=0 and the PC is re-fetched (hit).
- Outside RUN: `pc_we`=0 except in FILL with a pending redirect. `exc_valid`/`redirect_valid` arriving in REQ/BEAT are latched (exception overrides redirect; a later redirect does not override a latched exception) and the burst always completes; no abort.
- Counter width log2(LINE_WORDS); wraps to 0 on entering FILL.
- `nextpc` adder is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.

## Timing
- RUN outputs `nextpc`/`pc_we` are combinational from inputs; `mem_req`, `mem_addr`, `refill_idx`, `tag_we`, `busy` decode registered state.
- Reset (asynchronous, any state): state RUN, counter 0, pending flags clear, `miss_addr` 0; outputs `mem_req`=0, `refill_we`=0, `tag_we`=0, `busy`=0, `pc_we`=0, `nextpc`=RESET_PC while `rst` high. A mid-burst reset drops the burst; the memory side handles it.
- Miss penalty with ack every cycle: miss at cycle N → REQ at N+1, acks N+1..N+LINE_WORDS, FILL at N+LINE_WORDS+1, RUN (hit) at N+LINE_WORDS+2.
- `mem_req` deasserts the cycle after the first ack.

## Test plan
- Reset release, hits, no stall, `pc`=0 → `nextpc` 4, 8, 12 on consecutive cycles with `pc_we`=1; `busy`=0.
- Miss at `pc`=32'h0000_0044, LINE_WORDS=4, ack every cycle → `mem_addr`=32'h0000_0040, `refill_idx` 0,1,2,3, `tag_we` one cycle, `pc_we`=0 throughout, back to RUN 6 cycles after the miss.
- Miss with acks gapped (ack, idle, idle, ack, ack, ack) → exactly 4 `refill_we` pulses, idx advances only on ack.
- `redirect_valid` with `redirect_pc`=32'h0000_1000 during BEAT → burst completes, FILL cycle `nextpc`=32'h0000_1000, `pc_we`=1.
- `exc_valid` and `redirect_valid` in the same RUN cycle → `nextpc`=32'h8000_0180; `exc_valid` in REQ then redirect in BEAT → FILL loads EXC_VECTOR.
- `rst` asserted mid-BEAT → state RUN immediately (asynchronous), `mem_req`/`refill_we`/`busy`=0, `nextpc`=RESET_PC.
